// File: rtl/bitslice_serdes_ch.sv
// Multi-channel parallel <-> bit-slice converter with runtime word length.
// Converts CH words to and from SLICE-bit beats, LSB slice first, under a small command FSM.
module bitslice_serdes_ch #(
   parameter int CH              = 4,
   parameter int MAX_WORD_LENGTH = 32,
   parameter int SLICE           = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [1:0]                    mode,
   input  logic [$clog2(MAX_WORD_LENGTH+1)-1:0] word_len,
   input  logic [CH*MAX_WORD_LENGTH-1:0] par_in,
   input  logic [CH*SLICE-1:0]           slice_in,
   input  logic                          slice_in_valid,
   output logic [CH*SLICE-1:0]           slice_out,
   output logic                          slice_out_valid,
   input  logic                          slice_out_ready,
   output logic [CH*MAX_WORD_LENGTH-1:0] par_out,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int LW = $clog2(MAX_WORD_LENGTH+1);
   localparam int KW = $clog2(MAX_WORD_LENGTH/SLICE+1);
   localparam int W  = CH*MAX_WORD_LENGTH;
   localparam int BW = CH*SLICE;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SER  = 2'd1,
      S_DES  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t          state_q;
   logic [W-1:0]    word_q;
   logic [KW-1:0]   k_q;
   logic [KW-1:0]   n_q;
   logic [BW-1:0]   slice_out_q;
   logic            slice_out_valid_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;

   // Gathers slice k of every channel word into one beat.
   function automatic logic [BW-1:0] beat_of(input logic [W-1:0] w, input logic [KW-1:0] k);
      logic [BW-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         r[c*SLICE +: SLICE] = w[c*MAX_WORD_LENGTH + int'(k)*SLICE +: SLICE];
      end
      return r;
   endfunction

   function automatic logic len_ok(input logic [LW-1:0] len);
      return (len != '0) && ((int'(len) % SLICE) == 0) && (int'(len) <= MAX_WORD_LENGTH);
   endfunction

   function automatic logic [KW-1:0] beats_of(input logic [LW-1:0] len);
      return KW'(int'(len) / SLICE);
   endfunction

   // Command FSM with all status and data outputs registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         word_q            <= '0;
         k_q               <= '0;
         n_q               <= '0;
         slice_out_q       <= '0;
         slice_out_valid_q <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            // FIN behaves like IDLE for a new start so commands can run back to back.
            S_IDLE, S_FIN: begin
               done_q  <= (state_q == S_FIN);
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (start) begin
                  case (mode)
                     2'd1: begin
                        if (len_ok(word_len)) begin
                           word_q  <= '0;
                           k_q     <= '0;
                           n_q     <= beats_of(word_len);
                           busy_q  <= 1'b1;
                           state_q <= S_DES;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     2'd2: begin
                        word_q  <= par_in;
                        busy_q  <= 1'b1;
                        state_q <= S_FIN;
                     end
                     2'd3: begin
                        if (len_ok(word_len)) begin
                           k_q               <= '0;
                           n_q               <= beats_of(word_len);
                           busy_q            <= 1'b1;
                           slice_out_q       <= beat_of(word_q, KW'(0));
                           slice_out_valid_q <= 1'b1;
                           state_q           <= S_SER;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_SER: begin
               err_q <= start;
               if (slice_out_ready) begin
                  if (k_q == n_q - KW'(1)) begin
                     slice_out_q       <= '0;
                     slice_out_valid_q <= 1'b0;
                     state_q           <= S_FIN;
                  end else begin
                     k_q         <= k_q + KW'(1);
                     slice_out_q <= beat_of(word_q, k_q + KW'(1));
                  end
               end
            end
            S_DES: begin
               err_q <= start;
               if (slice_in_valid) begin
                  for (int c = 0; c < CH; c++) begin
                     word_q[c*MAX_WORD_LENGTH + int'(k_q)*SLICE +: SLICE] <= slice_in[c*SLICE +: SLICE];
                  end
                  if (k_q == n_q - KW'(1)) begin
                     state_q <= S_FIN;
                  end else begin
                     k_q <= k_q + KW'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign slice_out       = slice_out_q;
   assign slice_out_valid = slice_out_valid_q;
   assign par_out         = word_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_bitslice_serdes_ch.sv
// Directed bench for bitslice_serdes_ch: LOAD, SER, DES, error and reset cases.
// Outputs are sampled 1 time unit after each rising edge, where the inputs are also driven.
module tb_bitslice_serdes_ch;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   mode;
   logic [5:0]   word_len;
   logic [127:0] par_in;
   logic [15:0]  slice_in;
   logic         slice_in_valid;
   logic [15:0]  slice_out;
   logic         slice_out_valid;
   logic         slice_out_ready;
   logic [127:0] par_out;
   logic         busy;
   logic         done;
   logic         err;

   int vec_cnt = 0;
   int miss_cnt = 0;

   // LSB-first nibbles of DEADBEEF, 12345678 and CAFEF00D.
   logic [3:0] c0_tab [0:7] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
   logic [3:0] c1_tab [0:7] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
   logic [3:0] c2_tab [0:7] = '{4'hD, 4'h0, 4'h0, 4'hF, 4'hE, 4'hF, 4'hA, 4'hC};

   logic [127:0] load_word = {32'h0, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};

   bitslice_serdes_ch dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .mode            (mode),
      .word_len        (word_len),
      .par_in          (par_in),
      .slice_in        (slice_in),
      .slice_in_valid  (slice_in_valid),
      .slice_out       (slice_out),
      .slice_out_valid (slice_out_valid),
      .slice_out_ready (slice_out_ready),
      .par_out         (par_out),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_beat(input int i);
      return {4'h0, c2_tab[i], c1_tab[i], c0_tab[i]};
   endfunction

   initial begin
      int hs;
      int errs;
      int dones;
      int j;
      logic fire;
      logic [127:0] snap;
      logic [5:0] bad_len [0:2];
      bad_len = '{6'd0, 6'd6, 6'd36};

      reset = 1'b0; start = 1'b0; mode = 2'd0; word_len = 6'd0; par_in = '0;
      slice_in = '0; slice_in_valid = 1'b0; slice_out_ready = 1'b0;
      tick(); tick();
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_err", err, 1'b0);
      check_val("rst_valid", slice_out_valid, 1'b0);
      check_val("rst_slice", slice_out, 16'h0);
      check_val("rst_par", par_out, 128'h0);
      reset = 1'b1;
      tick();

      // LOAD: transit cycle busy, done in the following cycle.
      par_in = load_word; start = 1'b1; mode = 2'd2; word_len = 6'd32;
      tick();
      start = 1'b0;
      check_val("load_busy", busy, 1'b1);
      check_val("load_done_early", done, 1'b0);
      check_val("load_par", par_out, load_word);
      tick();
      check_val("load_done", done, 1'b1);
      check_val("load_busy_fin", busy, 1'b0);
      tick();
      check_val("load_done_once", done, 1'b0);

      // SER full length with ready held high.
      slice_out_ready = 1'b1; start = 1'b1; mode = 2'd3; word_len = 6'd32;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_val("ser32_valid", slice_out_valid, 1'b1);
         check_val("ser32_beat", slice_out, exp_beat(i));
         check_val("ser32_done_early", done, 1'b0);
         tick();
      end
      check_val("ser32_valid_end", slice_out_valid, 1'b0);
      check_val("ser32_slice_zero", slice_out, 16'h0);
      check_val("ser32_fin_done", done, 1'b0);
      tick();
      check_val("ser32_done", done, 1'b1);
      check_val("ser32_par_kept", par_out, load_word);
      tick();

      // SER len 16 with ready toggling and a rejected start mid-command.
      start = 1'b1; mode = 2'd3; word_len = 6'd16;
      tick();
      hs = 0; errs = 0; dones = 0; j = 0;
      while (j < 30 && dones == 0) begin
         if (slice_out_valid) check_val("ser16_beat", slice_out, exp_beat(hs));
         slice_out_ready = (j % 2 == 0);
         start = (j == 3);
         mode = 2'd1; word_len = 6'd8;
         fire = slice_out_valid && slice_out_ready;
         tick();
         if (fire) hs++;
         if (err) errs++;
         if (done) dones++;
         j++;
      end
      start = 1'b0;
      check_val("ser16_handshakes", hs, 4);
      check_val("ser16_err", errs, 1);
      check_val("ser16_done", dones, 1);
      check_val("ser16_cycles", j, 8);
      tick();

      // DES len 12 with valid gaps; ch0 gets 3,A,5 and ch1 gets 1,2,3.
      start = 1'b1; mode = 2'd1; word_len = 6'd12;
      tick();
      start = 1'b0;
      check_val("des_busy", busy, 1'b1);
      check_val("des_cleared", par_out, 128'h0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         slice_in_valid = (i == 0 || i == 2 || i == 5);
         slice_in = (i == 0) ? 16'h0013 : (i == 2) ? 16'h002A : (i == 5) ? 16'h0035 : 16'h00FF;
         tick();
         if (done) dones++;
      end
      slice_in_valid = 1'b0;
      check_val("des_par_fin", par_out, {64'h0, 32'h00000321, 32'h000005A3});
      check_val("des_busy_fin", busy, 1'b1);
      tick();
      if (done) dones++;
      check_val("des_done_cycle", done, 1'b1);
      tick();
      if (done) dones++;
      check_val("des_done_once", dones, 1);

      // Beats outside DES leave the word register alone.
      slice_in_valid = 1'b1; slice_in = 16'hFFFF;
      tick();
      slice_in_valid = 1'b0;
      check_val("des_idle_ignore", par_out, {64'h0, 32'h00000321, 32'h000005A3});

      // Illegal word lengths are rejected without touching state.
      snap = par_out;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; mode = (i == 1) ? 2'd1 : 2'd3; word_len = bad_len[i];
         tick();
         start = 1'b0;
         check_val("bad_len_err", err, 1'b1);
         check_val("bad_len_busy", busy, 1'b0);
         tick();
         check_val("bad_len_err_pulse", err, 1'b0);
         check_val("bad_len_par", par_out, snap);
      end
      start = 1'b1; mode = 2'd0; word_len = 6'd0;
      tick();
      start = 1'b0;
      check_val("nop_err", err, 1'b0);
      check_val("nop_busy", busy, 1'b0);

      // Back-to-back: DES issued while the LOAD sits in its final cycle.
      par_in = {96'h0, 32'h11111111}; start = 1'b1; mode = 2'd2;
      tick();
      check_val("b2b_load_par", par_out, {96'h0, 32'h11111111});
      mode = 2'd1; word_len = 6'd8;
      tick();
      start = 1'b0;
      check_val("b2b_load_done", done, 1'b1);
      check_val("b2b_err", err, 1'b0);
      check_val("b2b_busy", busy, 1'b1);
      check_val("b2b_cleared", par_out, 128'h0);
      slice_in_valid = 1'b1; slice_in = 16'h0007;
      tick();
      slice_in = 16'h0009;
      tick();
      slice_in_valid = 1'b0;
      tick();
      check_val("b2b_des_done", done, 1'b1);
      check_val("b2b_des_par", par_out, {96'h0, 32'h00000097});

      // Reset in the middle of a DES aborts without a done pulse.
      start = 1'b1; mode = 2'd1; word_len = 6'd32;
      tick();
      start = 1'b0; slice_in_valid = 1'b1; slice_in = 16'h1234;
      tick();
      slice_in_valid = 1'b0; reset = 1'b0;
      tick();
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_done", done, 1'b0);
      check_val("midrst_err", err, 1'b0);
      check_val("midrst_valid", slice_out_valid, 1'b0);
      check_val("midrst_slice", slice_out, 16'h0);
      check_val("midrst_par", par_out, 128'h0);
      reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) dones++;
      end
      check_val("midrst_no_done", dones, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
